// File: rtl/mix_clk_mon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mix_clk_mon_pkg
// Purpose  : Shared types and defaults for the mixer clock-frequency monitor.
//            Holds the FSM state encoding, the nominal 16 MHz / 6.4 MHz
//            operating point and the window-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package mix_clk_mon_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    COUNT  = 2'd2,
    REPORT = 2'd3
  } mon_state_e;

  // Nominal operating point: 16 MHz system clock, 6.4 MHz mixer clock.
  // The ratio is 2.5, so a 1600-cycle (100 us) gate sees 640 mixer edges.
  localparam int c_SYS_CLK_HZ     = 16_000_000;
  localparam int c_MON_CLK_HZ     = 6_400_000;
  localparam int c_WIN_CYC_DEF    = 1600;
  localparam int c_NOM_CNT        = 640;
  localparam int c_CNT_W_DEF      = 12;
  localparam int c_EXP_MIN_DEF    = 632;
  localparam int c_EXP_MAX_DEF    = 648;
  localparam int c_SYNC_STAGES_DEF = 2;

  // Width of a counter that runs 0..win_cyc-1 (kept at least one bit).
  function automatic int win_cnt_width(input int win_cyc);
    return (win_cyc > 1) ? $clog2(win_cyc) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mix_sync_edge.sv
`default_nettype none
// ============================================================================
// Module   : mix_sync_edge
// Purpose  : Brings an asynchronous clock into the clk domain through a
//            SYNC_STAGES flop chain and flags its rising edges.
// Ports    : clk      - sampling clock
//            rst_n    - asynchronous active-low reset
//            async_in - asynchronous input (monitored clock)
//            sync     - synchronized level of async_in
//            rise     - one-cycle pulse on a synchronized rising edge
// Revision : 1.0 - initial release
// ============================================================================
module mix_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync,
  output logic rise
);

  generate
    if (SYNC_STAGES < 2) begin : g_chk_sync_stages
      $error("mix_sync_edge: SYNC_STAGES must be at least 2");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync = r_sync[SYNC_STAGES-1];
  // The history flop lags sync by one cycle, so a detect lasts one cycle only.
  assign rise = sync & ~r_hist;

endmodule
`default_nettype wire

// File: rtl/mix_clk_mon.sv
`default_nettype none
// ============================================================================
// Module   : mix_clk_mon
// Purpose  : Counts rising edges of an asynchronous mixer clock over a fixed
//            gate window of clk cycles, reports the count and raises sticky
//            flags for out-of-range or stuck clocks.
// Ports    : clk      - 16 MHz system clock
//            rst_n    - asynchronous active-low reset
//            en       - run the monitor (level)
//            mon_clk  - monitored clock, asynchronous to clk
//            err_clr  - pulse that clears the sticky flags
//            cnt      - edge count of the last completed window
//            cnt_vld  - one-cycle pulse when cnt updates
//            freq_err - sticky, a window count fell outside EXP_MIN..EXP_MAX
//            stuck    - sticky, a window count was zero
//            busy     - monitor is not idle
// Revision : 1.0 - initial release
// ============================================================================
module mix_clk_mon
  import mix_clk_mon_pkg::*;
#(
  parameter int WIN_CYC     = c_WIN_CYC_DEF,
  parameter int CNT_W       = c_CNT_W_DEF,
  parameter int EXP_MIN     = c_EXP_MIN_DEF,
  parameter int EXP_MAX     = c_EXP_MAX_DEF,
  parameter int SYNC_STAGES = c_SYNC_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mon_clk,
  input  logic             err_clr,
  output logic [CNT_W-1:0] cnt,
  output logic             cnt_vld,
  output logic             freq_err,
  output logic             stuck,
  output logic             busy
);

  // A zero lower bound would let a stuck clock pass the range check, and an
  // upper bound the counter cannot reach would make the check meaningless.
  generate
    if (EXP_MIN <= 0) begin : g_chk_exp_min
      $error("mix_clk_mon: EXP_MIN must be greater than 0");
    end
    if (EXP_MAX >= (1 << CNT_W)) begin : g_chk_exp_max
      $error("mix_clk_mon: EXP_MAX must be below 2**CNT_W");
    end
  endgenerate

  localparam int                 c_WIN_W    = win_cnt_width(WIN_CYC);
  localparam int                 c_ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [c_WIN_W-1:0] c_WIN_LAST = c_WIN_W'(WIN_CYC - 1);
  localparam logic [c_ARM_W-1:0] c_ARM_LAST = c_ARM_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0]   c_CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]   c_EXP_MIN  = CNT_W'(EXP_MIN);
  localparam logic [CNT_W-1:0]   c_EXP_MAX  = CNT_W'(EXP_MAX);

  mon_state_e         r_state;
  mon_state_e         w_next;
  logic [c_ARM_W-1:0] r_arm_cnt;
  logic [c_WIN_W-1:0] r_win_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_cnt_vld;
  logic               r_freq_err;
  logic               r_stuck;
  logic               w_rise;
  logic               w_report;
  logic               w_set_ferr;
  logic               w_set_stuck;

  // The synchronized level itself is not needed here; only edges are counted.
  mix_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (mon_clk),
    .sync     (),
    .rise     (w_rise)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (en) w_next = ARM;
      ARM:     if (!en) w_next = IDLE;
               else if (r_arm_cnt == c_ARM_LAST) w_next = COUNT;
      COUNT:   if (!en) w_next = IDLE;
               else if (r_win_cnt == c_WIN_LAST) w_next = REPORT;
      REPORT:  w_next = en ? COUNT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  // ARM lasts SYNC_STAGES+1 cycles so edges already in the synchronizer when
  // the monitor starts never reach the edge counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_arm_cnt <= '0;
    end else if (r_state == ARM) begin
      r_arm_cnt <= r_arm_cnt + 1'b1;
    end else begin
      r_arm_cnt <= '0;
    end
  end

  // Both counters sit at zero outside COUNT, so every entry to COUNT (from
  // ARM or straight from REPORT) starts a clean window. An edge detected in
  // the REPORT cycle is lost, which is within the +/-1 tolerance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end else if (r_state == COUNT) begin
      r_win_cnt <= r_win_cnt + 1'b1;
      if (w_rise && (r_edge_cnt != c_CNT_MAX)) begin
        r_edge_cnt <= r_edge_cnt + 1'b1;
      end
    end else begin
      r_win_cnt  <= '0;
      r_edge_cnt <= '0;
    end
  end

  assign w_report    = (r_state == REPORT);
  assign w_set_ferr  = w_report && ((r_edge_cnt < c_EXP_MIN) || (r_edge_cnt > c_EXP_MAX));
  assign w_set_stuck = w_report && (r_edge_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_cnt_vld  <= 1'b0;
      r_freq_err <= 1'b0;
      r_stuck    <= 1'b0;
    end else begin
      r_cnt_vld <= w_report;
      if (w_report) begin
        r_cnt <= r_edge_cnt;
      end
      // A new error always wins over a clear arriving in the same cycle.
      if (w_set_ferr) begin
        r_freq_err <= 1'b1;
      end else if (err_clr) begin
        r_freq_err <= 1'b0;
      end
      if (w_set_stuck) begin
        r_stuck <= 1'b1;
      end else if (err_clr) begin
        r_stuck <= 1'b0;
      end
    end
  end

  assign cnt      = r_cnt;
  assign cnt_vld  = r_cnt_vld;
  assign freq_err = r_freq_err;
  assign stuck    = r_stuck;
  assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_mix_clk_mon.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mix_clk_mon
// Purpose  : Self-checking bench for mix_clk_mon. A default instance and a
//            narrow-counter (CNT_W=8) instance share all inputs. Expected
//            counts come from the mixer-clock frequency chosen for each run.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mix_clk_mon;

  localparam int c_LAT_FIRST = 1604;
  localparam int c_PERIOD    = 1601;
  localparam int c_LO        = 632;
  localparam int c_HI        = 648;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        err_clr = 1'b0;
  logic        mon_clk;
  logic [11:0] cnt;
  logic        cnt_vld, freq_err, stuck, busy;
  logic [7:0]  cnt8;
  logic        cnt_vld8, freq_err8, stuck8, busy8;

  int  n_checks = 0;
  int  n_pass   = 0;
  real mon_half = 78.125;
  bit  mon_run  = 1'b0;
  int  exp_n    = 0;     // true edges per 100 us window, 0 means stopped
  bit  exp_ferr, exp_stuck, exp_ferr8, exp_stuck8;
  bit  clr_rep  = 1'b0;  // err_clr is sampled on the same edge as the report

  mix_clk_mon dut (
    .clk (clk), .rst_n (rst_n), .en (en), .mon_clk (mon_clk), .err_clr (err_clr),
    .cnt (cnt), .cnt_vld (cnt_vld), .freq_err (freq_err), .stuck (stuck), .busy (busy)
  );

  mix_clk_mon #(
    .WIN_CYC (1600), .CNT_W (8), .EXP_MIN (100), .EXP_MAX (200), .SYNC_STAGES (2)
  ) dut8 (
    .clk (clk), .rst_n (rst_n), .en (en), .mon_clk (mon_clk), .err_clr (err_clr),
    .cnt (cnt8), .cnt_vld (cnt_vld8), .freq_err (freq_err8), .stuck (stuck8), .busy (busy8)
  );

  always #31.25 clk = ~clk;

  initial begin
    mon_clk = 1'b0;
    forever begin
      if (mon_run) begin
        mon_clk = 1'b1; #(mon_half);
        mon_clk = 1'b0; #(mon_half);
      end else begin
        mon_clk = 1'b0; #5;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  // Edge count per window for a kind: 0 in range, 1 slow, 2 fast.
  function automatic int pick_n(input int kind);
    case (kind)
      0:       return 636 + int'($urandom_range(0, 8));
      1:       return 300 + int'($urandom_range(0, 300));
      default: return 660 + int'($urandom_range(0, 100));
    endcase
  endfunction

  task automatic set_mon(input int n);
    exp_n = n;
    if (n == 0) begin
      mon_run = 1'b0;
    end else begin
      mon_half = 50000.0 / n;  // 100 us window holds n full periods
      mon_run  = 1'b1;
    end
  endtask

  task automatic wait_vld(input int max_cyc, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!cnt_vld && lat < max_cyc);
    if (!cnt_vld) check("vld_timeout", 0, 1);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_ferr"},   freq_err,  exp_ferr);
    check({tag, "_stuck"},  stuck,     exp_stuck);
    check({tag, "_ferr8"},  freq_err8, exp_ferr8);
    check({tag, "_stuck8"}, stuck8,    exp_stuck8);
  endtask

  task automatic check_window();
    bit bad = (exp_n == 0) || (exp_n < c_LO) || (exp_n > c_HI);
    if (exp_n == 0) check("cnt_zero", cnt, 0);
    else            check("cnt_in_tol", (int'(cnt) >= exp_n - 1) && (int'(cnt) <= exp_n + 1), 1);
    check("vld8", cnt_vld8, 1);
    check("cnt8", cnt8, (exp_n == 0) ? 0 : 255);
    if (bad)          exp_ferr = 1'b1;
    else if (clr_rep) exp_ferr = 1'b0;
    if (exp_n == 0)   exp_stuck = 1'b1;
    else if (clr_rep) exp_stuck = 1'b0;
    exp_ferr8 = 1'b1;  // 0 and 255 are both outside 100..200
    if (exp_n == 0)   exp_stuck8 = 1'b1;
    else if (clr_rep) exp_stuck8 = 1'b0;
    clr_rep = 1'b0;
    check_flags("win");
  endtask

  task automatic next_window();
    int lat;
    wait_vld(c_PERIOD + 100, lat);
    check("period", lat, c_PERIOD);
    check_window();
  endtask

  task automatic start_and_measure();
    int lat;
    @(posedge clk); #1;
    check("busy_rise", busy, 1);
    wait_vld(c_LAT_FIRST + 100, lat);
    check("first_latency", lat, c_LAT_FIRST);
    check_window();
  endtask

  // Called just after a report, so the abort lands early in a window.
  task automatic restart(input int n);
    @(negedge clk); en = 1'b0;
    repeat (40) @(negedge clk);
    set_mon(n);
    repeat (10) @(negedge clk);
    en = 1'b1;
    start_and_measure();
  endtask

  task automatic pulse_clr();
    @(negedge clk); err_clr = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    exp_ferr = 1'b0; exp_stuck = 1'b0; exp_ferr8 = 1'b0; exp_stuck8 = 1'b0;
    check_flags("clr");
  endtask

  initial begin
    int lat;
    int nv;
    logic [11:0] saved;

    #100;
    check("rst_cnt", cnt, 0);
    check("rst_vld", cnt_vld, 0);
    check("rst_busy", busy, 0);
    check("rst_cnt8", cnt8, 0);
    exp_ferr = 0; exp_stuck = 0; exp_ferr8 = 0; exp_stuck8 = 0;
    check_flags("rst");
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("idle_busy", busy, 0);

    // Nominal clock, monitor enabled from idle, then back-to-back windows.
    set_mon(pick_n(0));
    @(negedge clk); en = 1'b1;
    start_and_measure();
    next_window();
    next_window();

    // Random frequencies, each run restarted from idle.
    for (int i = 0; i < 4; i++) begin
      restart(pick_n(int'($urandom_range(0, 2))));
      next_window();
    end

    // Stopped clock, then good windows keep the flags until a clear.
    restart(0);
    restart(pick_n(0));
    repeat (100) @(posedge clk);
    pulse_clr();
    wait_vld(c_PERIOD, lat);
    check_window();

    // 4 MHz clock, clear arriving on the same edge as an error report.
    restart(400);
    repeat (1600) @(posedge clk);
    @(negedge clk); err_clr = 1'b1; clr_rep = 1'b1;
    @(posedge clk); #1; err_clr = 1'b0;
    check("vld_with_clr", cnt_vld, 1);
    check_window();

    // Abort mid-window: no report, previous result kept, re-arm afterwards.
    restart(pick_n(0));
    saved = cnt;
    repeat (799) @(posedge clk);
    @(negedge clk); en = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    nv = 0;
    repeat (1700) begin
      @(posedge clk); #1;
      if (cnt_vld || cnt_vld8) nv++;
    end
    check("abort_no_vld", nv, 0);
    check("abort_cnt_kept", cnt, saved);
    check_flags("abort");
    @(negedge clk); en = 1'b1;
    start_and_measure();

    // Asynchronous reset in the middle of a window with flags set.
    restart(pick_n(2));
    repeat (500) @(posedge clk);
    #20 rst_n = 1'b0;
    #1;
    check("arst_cnt", cnt, 0);
    check("arst_vld", cnt_vld, 0);
    check("arst_busy", busy, 0);
    check("arst_cnt8", cnt8, 0);
    exp_ferr = 0; exp_stuck = 0; exp_ferr8 = 0; exp_stuck8 = 0;
    check_flags("arst");
    @(negedge clk); rst_n = 1'b1;
    start_and_measure();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mix_clk_mon.md
# mix_clk_mon

Synthesizable clock-frequency monitor that receives an asynchronous mixer-side clock and checks it against the 16 MHz system clock. It counts rising edges of the monitored clock over a fixed gate window of system-clock cycles. It reports the count and flags out-of-range or stuck clocks. It sits beside the mixer clocking and feeds the status/control block, which holds `en` low until reset release plus settling.

## Interface
Parameters:
- `WIN_CYC`, 1600: gate window length in `clk` cycles (100 µs at 16 MHz).
- `CNT_W`, 12: edge counter / `cnt` width.
- `EXP_MIN`, 632: lowest in-range count, inclusive.
- `EXP_MAX`, 648: highest in-range count, inclusive.
- `SYNC_STAGES`, 2: synchronizer depth, ≥2.

Ports:
- `clk`  in  1: 16 MHz system clock; all logic on rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `en`  in  1: run monitor; level-sensitive.
- `mon_clk`  in  1: monitored clock, asynchronous to `clk`; high and low phases each >1 `clk` period.
- `err_clr`  in  1: one-cycle pulse; clears sticky flags.
- `cnt`  out  CNT_W: edge count of the last completed window.
- `cnt_vld`  out  1: one-cycle pulse when `cnt` updates.
- `freq_err`  out  1: sticky; a completed window had count < EXP_MIN or > EXP_MAX.
- `stuck`  out  1: sticky; a completed window had count == 0.
- `busy`  out  1: high in any state except IDLE.

## Operation
- `mon_clk` passes through a SYNC_STAGES flop chain plus one history flop. A rising edge is detected as sync=1, history=0; this gives at most one detect per `clk` cycle.
- FSM states: IDLE, ARM, COUNT, REPORT.
  - IDLE: counters held at 0. Goes to ARM when `en`=1.
  - ARM: SYNC_STAGES+1 cycles to flush the synchronizer; any detected edges are discarded. Then goes to COUNT.
  - COUNT: the window counter runs 0..WIN_CYC-1 and the edge counter increments on each detect. The edge counter saturates at 2^CNT_W-1 with no wrap. After cycle WIN_CYC-1, goes to REPORT.
  - REPORT: one cycle. Latches `cnt`, pulses `cnt_vld` and evaluates the range. Next state is COUNT if `en`=1, otherwise IDLE. Both counters clear on entry to COUNT.
- `en` falling in ARM or COUNT aborts to IDLE on the next cycle. There is no `cnt_vld`, and `cnt` and the flags are unchanged.
- Range check uses unsigned compare. `stuck` implies `freq_err`, because EXP_MIN > 0 is required; elaboration must fail otherwise. Elaboration must also fail if EXP_MAX ≥ 2^CNT_W.
- Sticky flags: set has priority over `err_clr` in the same cycle. Otherwise `err_clr`=1 clears both flags.

## Timing
- Reset values: `cnt`=0, `cnt_vld`=0, `freq_err`=0, `stuck`=0, `busy`=0, FSM=IDLE, synchronizer flops=0.
- `busy` rises the cycle after `en` is first sampled high in IDLE.
- First `cnt_vld`: 1 + (SYNC_STAGES+1) + WIN_CYC cycles after `en` is sampled high in IDLE. With defaults that is 1604 cycles.
- Back-to-back windows repeat every WIN_CYC+1 cycles. An edge detected during the REPORT cycle is dropped, which is covered by the tolerance.
- `freq_err` and `stuck` update in the same cycle as `cnt_vld`.
- Edge detect latency from a `mon_clk` rise is SYNC_STAGES to SYNC_STAGES+1 `clk` cycles.
- Measurement accuracy: the true edge count ±1.

## Structure
- Package `mix_clk_mon_pkg` holds:
  - FSM state enum `mon_state_e` (IDLE, ARM, COUNT, REPORT);
  - default localparams for the 16 MHz / 6.4 MHz nominal pair (ratio 2.5, nominal count 640);
  - a function computing `$clog2(WIN_CYC)` for the window counter width.
- Sub-module `mix_sync_edge` contains the parameterized synchronizer and rising-edge detector. It has outputs `sync` and `rise`, plus `clk` and `rst_n`.
- The top level contains the FSM, window counter, edge counter, `cnt` register and flag logic.

## Test plan
- 16 MHz `clk`, 6.4 MHz `mon_clk`, `en`=1 after reset → first `cnt_vld` at cycle 1604. `cnt` is 639–641, `freq_err`=0, `stuck`=0, then `cnt_vld` every 1601 cycles.
- `mon_clk` held 0 → `cnt`=0, `stuck`=1, `freq_err`=1; flags stay set over following good windows until `err_clr`.
- 4 MHz `mon_clk` → `cnt` is 399–401 and `freq_err`=1. Then pulse `err_clr` together with the next out-of-range `cnt_vld` → `freq_err` remains 1.
- `en` dropped at window cycle 800 → IDLE next cycle, `busy`=0, no `cnt_vld`, previous `cnt` retained. Re-asserting `en` re-runs ARM.
- `rst_n` asserted mid-COUNT (asynchronous, between `clk` edges) → all outputs at reset values immediately. After release with `en`=1, the full 1604-cycle latency applies again.
- Fast `mon_clk` with WIN_CYC=1600, CNT_W=8 (EXP bounds adjusted) → `cnt` saturates at 255 with no wrap, and `freq_err`=1.
